// File: rtl/integrator_sched_pkg.sv
// Shared types and result helpers for the time-multiplexed integrator.
// INTEGRATOR_SAT_EN selects clamp-on-overflow; otherwise results wrap.
package integrator_sched_types;

    localparam int SAMPLE_W = 10;
    localparam int CH_W     = 4;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef struct packed {
        logic [CH_W-1:0] ch;
        sample_t         data;
        logic            ovf;
    } result_t;

    function automatic logic [CH_W+SAMPLE_W:0] result_to_lv(input result_t r);
        return {r.ch, r.data, r.ovf};
    endfunction

    // sum is a sign-extended (dw+1)-bit value; caller keeps the low dw bits.
    function automatic logic signed [31:0] sat_wrap(input logic signed [31:0] sum,
                                                    input int dw);
`ifdef INTEGRATOR_SAT_EN
        logic signed [31:0] max_v;
        logic signed [31:0] min_v;
        max_v = (32'sd1 <<< (dw - 1)) - 32'sd1;
        min_v = -(32'sd1 <<< (dw - 1));
        if (sum > max_v) begin
            return max_v;
        end else if (sum < min_v) begin
            return min_v;
        end
        return sum;
`else
        return (sum <<< (32 - dw)) >>> (32 - dw);
`endif
    endfunction

endpackage

// File: rtl/integrator_rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus index, searching upward from ptr.
// Latency: combinational grant; ptr advances past the winner at the edge.
// Backpressure: en=0 forces an all-zero grant and freezes ptr.
module integrator_rr_arbiter #(
    parameter  int NCH = 4,
    localparam int CW  = $clog2(NCH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] req_valid,
    input  logic           en,
    output logic [NCH-1:0] gnt,
    output logic           gnt_vld,
    output logic [CW-1:0]  gnt_idx
);

    logic [CW-1:0] ptr;
    logic [CW-1:0] ptr_nxt;

    always_comb begin
        int            idx_i;
        logic [CW-1:0] idx;
        gnt     = '0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NCH; k++) begin
            idx_i = int'(ptr) + k;
            if (idx_i >= NCH) begin
                idx_i = idx_i - NCH;
            end
            idx = CW'(idx_i);
            if (en && !gnt_vld && req_valid[idx]) begin
                gnt_vld  = 1'b1;
                gnt_idx  = idx;
                gnt[idx] = 1'b1;
            end
        end
        ptr_nxt = ptr;
        if (gnt_vld) begin
            ptr_nxt = (int'(gnt_idx) == NCH - 1) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/integrator_sched.sv
// Shares one signed integrator across NCH channels with round-robin grants.
// Latency: one cycle, sample accepted at edge N appears on out_* after edge N.
// Backpressure: out_valid && !out_ready freezes out_* and grants nothing.
// Build option: define INTEGRATOR_SAT_EN to saturate instead of wrap.
module integrator_sched
    import integrator_sched_types::*;
#(
    parameter  int NCH = 4,
    parameter  int DW  = 10,
    localparam int CW  = $clog2(NCH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    req_valid,
    input  logic [NCH*DW-1:0] req_data,
    output logic [NCH-1:0]    req_ready,
    input  logic [NCH-1:0]    clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CW-1:0]     out_ch,
    output logic [DW-1:0]     out_data,
    output logic              out_ovf
);

    logic [DW-1:0]      acc [NCH];
    logic               adv;
    logic [NCH-1:0]     gnt;
    logic               gnt_vld;
    logic [CW-1:0]      gnt_idx;
    logic [DW-1:0]      sample;
    logic [DW-1:0]      acc_sel;
    logic [DW:0]        sum;
    logic               ovf;
    logic signed [31:0] res_full;
    logic [DW-1:0]      result;
    logic               unused_res_hi;

    // Reset also masks grants so req_ready stays low while rst is held.
    assign adv = (!out_valid || out_ready) && !rst;

    integrator_rr_arbiter #(.NCH(NCH)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .en        (adv),
        .gnt       (gnt),
        .gnt_vld   (gnt_vld),
        .gnt_idx   (gnt_idx)
    );

    assign req_ready = gnt;

    // A clear on the granted channel zeroes the operand before the add.
    always_comb begin
        sample  = '0;
        acc_sel = '0;
        for (int i = 0; i < NCH; i++) begin
            if (gnt[i]) begin
                sample  = req_data[i*DW +: DW];
                acc_sel = clr[i] ? '0 : acc[i];
            end
        end
        sum      = {acc_sel[DW-1], acc_sel} + {sample[DW-1], sample};
        ovf      = sum[DW] ^ sum[DW-1];
        res_full = sat_wrap(32'($signed(sum)), DW);
        result   = res_full[DW-1:0];
    end

    assign unused_res_hi = ^res_full[31:DW];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                acc[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (gnt[i]) begin
                    acc[i] <= result;
                end else if (clr[i]) begin
                    acc[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else if (gnt_vld) begin
            out_valid <= 1'b1;
            out_ch    <= gnt_idx;
            out_data  <= result;
            out_ovf   <= ovf;
        end else if (adv) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_integrator_sched.sv
// Scoreboarded bench for integrator_sched: a reference model predicts grants
// and results every cycle; scenario tasks add directed spot checks.
module tb_integrator_sched;
    import integrator_sched_types::*;

    localparam int NCH = 4;
    localparam int DW  = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    req_valid;
    logic [NCH*DW-1:0] req_data;
    logic [NCH-1:0]    req_ready;
    logic [NCH-1:0]    clr;
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        out_ch;
    logic [DW-1:0]     out_data;
    logic              out_ovf;

    int errors = 0;
    int checks = 0;

    result_t exp_q[$];
    int      acc_m[NCH];
    int      mptr;
    logic    m_ov;

    always #5 clk = ~clk;

    integrator_sched #(.NCH(NCH), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .clr       (clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    // Reference model: samples inputs just before each rising edge.
    initial begin
        int             g;
        int             base;
        int             samp;
        int             sum;
        int             res;
        logic           adv;
        logic           ovf;
        logic           pending;
        logic [NCH-1:0] exp_rdy;
        result_t        e;
        result_t        got;
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                for (int i = 0; i < NCH; i++) acc_m[i] = 0;
                mptr = 0;
                m_ov = 1'b0;
                exp_q.delete();
            end else begin
                adv     = !m_ov || out_ready;
                g       = -1;
                pending = 1'b0;
                if (adv) begin
                    for (int k = 0; k < NCH; k++) begin
                        if (g < 0 && req_valid[(mptr + k) % NCH]) g = (mptr + k) % NCH;
                    end
                end
                exp_rdy = '0;
                if (g >= 0) exp_rdy[g] = 1'b1;
                checks++;
                if (req_ready !== exp_rdy) begin
                    errors++;
                    $display("FAIL req_ready: got %b want %b", req_ready, exp_rdy);
                end
                if (g >= 0) begin
                    base = clr[g] ? 0 : acc_m[g];
                    samp = int'($signed(req_data[g*DW +: DW]));
                    sum  = base + samp;
                    ovf  = (sum > 511) || (sum < -512);
`ifdef INTEGRATOR_SAT_EN
                    res = (sum > 511) ? 511 : (sum < -512) ? -512 : sum;
`else
                    res = (sum > 511) ? sum - 1024 : (sum < -512) ? sum + 1024 : sum;
`endif
                    e.ch   = 4'(g);
                    e.data = sample_t'(res);
                    e.ovf  = ovf;
                    exp_q.push_back(e);
                    mptr    = (g + 1) % NCH;
                    m_ov    = 1'b1;
                    pending = 1'b1;
                end else if (adv) begin
                    m_ov = 1'b0;
                end
                for (int i = 0; i < NCH; i++) begin
                    if (clr[i] && i != g) acc_m[i] = 0;
                end
                if (g >= 0) acc_m[g] = res;
                @(posedge clk);
                #1;
                if (!rst) begin
                    checks++;
                    if (out_valid !== m_ov) begin
                        errors++;
                        $display("FAIL out_valid: got %b want %b", out_valid, m_ov);
                    end
                    if (pending && exp_q.size() > 0) begin
                        e        = exp_q.pop_front();
                        got.ch   = 4'(out_ch);
                        got.data = out_data;
                        got.ovf  = out_ovf;
                        checks++;
                        if (result_to_lv(got) !== result_to_lv(e)) begin
                            errors++;
                            $display("FAIL scoreboard: got ch=%0d data=%0d ovf=%b want ch=%0d data=%0d ovf=%b",
                                     got.ch, got.data, got.ovf, e.ch, e.data, e.ovf);
                        end
                    end
                end
            end
        end
    end

    task automatic clear_all();
        @(negedge clk);
        req_valid = '0;
        clr       = '1;
        @(negedge clk);
        clr = '0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        out_ready = 1'b1;
        clr       = '0;
        req_valid = '1;
        req_data  = '0;
        #2;
        checks++;
        if (req_ready !== '0 || out_valid !== 1'b0 || out_data !== '0 || out_ch !== '0 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b vld=%b ch=%0d data=%0d ovf=%b want all 0",
                     req_ready, out_valid, out_ch, out_data, out_ovf);
        end
        @(negedge clk);
        rst       = 1'b0;
        req_valid = 4'b0001;
        req_data[0 +: DW] = 10'd3;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || req_ready !== '0) begin
            errors++;
            $display("FAIL reset_async: got vld=%b data=%0d rdy=%b want 0 0 0", out_valid, out_data, req_ready);
        end
        @(negedge clk);
        rst       = 1'b0;
        req_data[0 +: DW] = 10'd5;
        @(posedge clk);
        #1;
        checks++;
        if (out_data !== 10'd5 || out_ch !== 2'd0) begin
            errors++;
            $display("FAIL reset_first: got ch=%0d data=%0d want ch=0 data=5", out_ch, out_data);
        end
        @(negedge clk);
        req_valid = '0;
    endtask

    task automatic test_single();
        clear_all();
        @(negedge clk);
        req_valid = 4'b0001;
        req_data[0 +: DW] = 10'd100;
        @(posedge clk);
        #1;
        checks++;
        if (out_ch !== 2'd0 || out_data !== 10'd100) begin
            errors++;
            $display("FAIL single_1: got ch=%0d data=%0d want ch=0 data=100", out_ch, out_data);
        end
        @(negedge clk);
        req_data[0 +: DW] = 10'd200;
        @(posedge clk);
        #1;
        checks++;
        if (out_ch !== 2'd0 || out_data !== 10'd300) begin
            errors++;
            $display("FAIL single_2: got ch=%0d data=%0d want ch=0 data=300", out_ch, out_data);
        end
        @(negedge clk);
        req_valid = '0;
    endtask

    task automatic test_fairness();
        clear_all();
        @(negedge clk);
        req_valid = 4'b1000;
        req_data  = '0;
        @(negedge clk);
        req_valid = '1;
        for (int i = 0; i < NCH; i++) req_data[i*DW +: DW] = DW'(i * 7 - 10);
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_ch !== 2'(c % NCH) || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL fairness[%0d]: got ch=%0d vld=%b want ch=%0d vld=1", c, out_ch, out_valid, c % NCH);
            end
        end
        @(negedge clk);
        req_valid = '0;
    endtask

    task automatic test_overflow();
        int exp_d;
        clear_all();
        @(negedge clk);
        req_valid = 4'b0010;
        req_data[DW +: DW] = 10'd500;
        @(negedge clk);
        req_data[DW +: DW] = 10'd20;
        @(posedge clk);
        #1;
`ifdef INTEGRATOR_SAT_EN
        exp_d = 511;
`else
        exp_d = -504;
`endif
        checks++;
        if (int'($signed(out_data)) !== exp_d || out_ovf !== 1'b1 || out_ch !== 2'd1) begin
            errors++;
            $display("FAIL overflow: got ch=%0d data=%0d ovf=%b want ch=1 data=%0d ovf=1",
                     out_ch, $signed(out_data), out_ovf, exp_d);
        end
        @(negedge clk);
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        logic [1:0]    h_ch;
        logic [DW-1:0] h_data;
        logic          h_ovf;
        clear_all();
        @(negedge clk);
        req_valid = 4'b1000;
        req_data  = '0;
        @(negedge clk);
        req_valid = '1;
        for (int i = 0; i < NCH; i++) req_data[i*DW +: DW] = DW'(i + 1);
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        h_ch   = out_ch;
        h_data = out_data;
        h_ovf  = out_ovf;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (req_ready !== '0) begin
                errors++;
                $display("FAIL bp_ready[%0d]: got %b want 0000", c, req_ready);
            end
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_ch !== h_ch || out_data !== h_data || out_ovf !== h_ovf || h_ch !== 2'd1) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got vld=%b ch=%0d data=%0d want vld=1 ch=1 data=%0d",
                         c, out_valid, out_ch, out_data, h_data);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_ch !== 2'd2) begin
            errors++;
            $display("FAIL bp_resume: got ch=%0d want ch=2", out_ch);
        end
        @(negedge clk);
        req_valid = '0;
    endtask

    task automatic test_clear_collision();
        clear_all();
        @(negedge clk);
        req_valid = 4'b0100;
        req_data[2*DW +: DW] = 10'd50;
        @(negedge clk);
        clr = 4'b0100;
        req_data[2*DW +: DW] = 10'd7;
        @(posedge clk);
        #1;
        checks++;
        if (out_data !== 10'd7 || out_ch !== 2'd2) begin
            errors++;
            $display("FAIL clr_collide: got ch=%0d data=%0d want ch=2 data=7", out_ch, out_data);
        end
        @(negedge clk);
        clr = '0;
        req_data[2*DW +: DW] = 10'd1;
        @(posedge clk);
        #1;
        checks++;
        if (out_data !== 10'd8) begin
            errors++;
            $display("FAIL clr_next: got data=%0d want data=8", out_data);
        end
        @(negedge clk);
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_overflow();
        test_backpressure();
        test_clear_collision();
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
